pipeline_stage_chain: RTL
=========================

# pipeline_stage_chain

Parametrised, elastic pipeline-register chain carrying a data word plus its decoded control bundle through `STAGES` registers. Generalises the fixed per-stage IF/ID, ID/EX, EX/MEM and MEM/WB registers:
- adds per-stage valid bits, a valid/ready handshake at both ends, per-stage stall (hold) and flush (bubble insertion with a NOP control word);
- adds an occupancy counter and a squashed-instruction counter.

It sits between the control unit and the execute/memory/writeback datapath.

## Interface
Parameters:
- `DW`, 32, data word width (instruction/operand bus)
- `CW`, 16, control bundle width (packed control signals)
- `STAGES`, 3, number of register stages, 1..8
- `NOP_CTRL`, all zeros, control value loaded into a flushed or reset stage

Ports (`CW`-wide control, `STAGES`-wide masks):
- `Clk` in 1: single clock, all state updates on posedge
- `R` in 1: reset, asynchronous, active-low
- `in_valid` in 1: upstream offers `in_data`/`in_ctrl`
- `in_ready` out 1: stage 0 accepts this cycle
- `in_data` in DW; `in_ctrl` in CW
- `stall` in STAGES: bit k holds stage k
- `flush` in STAGES: bit k squashes stage k
- `out_valid` out 1: last stage presents an entry
- `out_ready` in 1: consumer takes the entry
- `out_data` out DW; `out_ctrl` out CW: contents of stage STAGES-1
- `stage_valid` out STAGES: registered valid bit per stage
- `occupancy` out clog2(STAGES+1): count of set `stage_valid` bits
- `flush_count` out 16: saturating count of valid entries squashed by flush

## Operation
- Per stage k: registers `v[k]`, `d[k]`, `c[k]`.
- `avail[k] = v[k] & ~stall[k] & ~flush[k]`. `avail[-1] = in_valid`.
- `rdy[k] = ~stall[k] & ~flush[k] & (~v[k] | rdy[k+1])`. `rdy[STAGES] = out_ready`.
- `in_ready = rdy[0]`, `out_valid = avail[STAGES-1]`, `out_data = d[STAGES-1]`, `out_ctrl = c[STAGES-1]`.
- Next state of stage k, in priority order:
  1. `flush[k]`: `v=0`, `c=NOP_CTRL`, `d=0`.
  2. else `stall[k]`: hold.
  3. else `rdy[k]`: load from stage k-1 (or input). `v = avail[k-1]`; when `avail[k-1]=0`, `c=NOP_CTRL` and `d` holds.
  4. else hold.
- Flush takes priority over stall and over load. A flushed stage neither emits downstream nor accepts from upstream that cycle; upstream holds.
- Stall on a valid stage back-pressures all upstream stages that are full (combinational `rdy` chain). Downstream stages keep draining and collapse bubbles.
- Bubbles are never emitted: `out_valid` is 0 when the last stage is empty, stalled or flushed.
- `flush_count += popcount(v & flush)` per edge, saturating at 0xFFFF.
- `occupancy` is combinational from `v`.
- Ordering is strictly FIFO; no entry is duplicated or reordered.

## Timing
- Reset (`R=0`), immediate and asynchronous:
  - all `v=0`, `c=NOP_CTRL`, `d=0`, `flush_count=0`;
  - `out_valid=0`, `occupancy=0`;
  - `in_ready` follows `rdy[0]` (1 unless `stall[0]`/`flush[0]`).
- Reset release is synchronous to the first posedge with `R=1`.
- Latency: an entry accepted at edge n appears on `out_*` after edge n+STAGES-1, i.e. STAGES cycles from input to consumption, with no stall and `out_ready=1`.
- Throughput: 1 entry/cycle at full chain with `out_ready=1`, including full-and-draining simultaneously.
- `in_ready` and `out_valid` are combinational from registered state and `stall`/`flush`/`out_ready`. No path exists from `in_valid` to `in_ready`.
- Boundaries:
  - Full chain with `out_ready=0`: `in_ready=0`, state holds.
  - Flush of the last stage while `out_ready=1`: no transfer occurs.
  - `STAGES=1`: single register with the same rules.
  - Reset mid-stream discards all entries; entries are not counted in `flush_count`.

## Test plan
- STAGES=3, reset, then inputs 0x11, 0x22, 0x33 on consecutive cycles with `out_ready=1` -> `out_data` shows 0x11/0x22/0x33 on cycles 3/4/5 after the first accept; `occupancy` peaks at 3.
- `out_ready=0`, stream 4 entries -> 3 accepted, `in_ready=0` on the 4th, `occupancy=3`; raise `out_ready` -> entries exit in order, 4th accepted the same cycle the first leaves.
- Full chain, `stall=3'b010` for 2 cycles, `out_ready=1` -> stage 2 emits its entry, then `out_valid=0` for the bubble; stage 0/1 hold, `in_ready=0`; after release no loss or duplication.
- 3 valid entries, `flush=3'b110` for one cycle -> next cycle `stage_valid=3'b001`, `c[1]=c[2]=NOP_CTRL`, `flush_count=2`, `out_valid=0`.
- `stall[1]` and `flush[1]` together on a valid stage -> flush wins: stage 1 empty, `flush_count` +1.
- Assert `R=0` mid-stream between clock edges -> `stage_valid=0`, `out_valid=0`, `flush_count=0` without waiting for `Clk`. Preload `flush_count=0xFFFF` via repeated flushes -> stays 0xFFFF.

Source files
------------

// File: rtl/pipeline_stage_chain.sv
// rtl/pipeline_stage_chain.sv - elastic pipeline-register chain with per-stage stall, flush and squash counting
// Ready ripples back combinationally from out_ready; data and control move one stage per accepted edge.
module pipeline_stage_chain #(
  parameter int DW = 32,
  parameter int CW = 16,
  parameter int STAGES = 3,
  parameter logic [CW-1:0] NOP_CTRL = '0
) (
  input  logic                            Clk,
  input  logic                            R,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DW-1:0]                   in_data,
  input  logic [CW-1:0]                   in_ctrl,
  input  logic [STAGES-1:0]               stall,
  input  logic [STAGES-1:0]               flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DW-1:0]                   out_data,
  output logic [CW-1:0]                   out_ctrl,
  output logic [STAGES-1:0]               stage_valid,
  output logic [$clog2(STAGES+1)-1:0]     occupancy,
  output logic [15:0]                     flush_count
);

  localparam int OW = $clog2(STAGES + 1);

  logic [STAGES-1:0] v_q;
  logic [DW-1:0]     d_q [STAGES];
  logic [CW-1:0]     c_q [STAGES];
  logic [15:0]       fc_q;

  logic [STAGES-1:0] open_s;
  logic [STAGES-1:0] avail;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] src_v;
  logic [DW-1:0]     src_d [STAGES];
  logic [CW-1:0]     src_c [STAGES];
  logic [3:0]        squash_n;
  logic [OW-1:0]     occ;
  logic [16:0]       fc_sum;

  assign open_s = ~stall & ~flush;
  assign avail  = v_q & open_s;

  // Walk from the sink back to stage 0 so each stage sees its successor's ready.
  always_comb begin
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = open_s[k] & (~v_q[k] | r);
      rdy[k] = r;
    end
  end

  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    src_d[0] = in_data;
    src_c[0] = in_ctrl;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = avail[k-1];
      src_d[k] = d_q[k-1];
      src_c[k] = c_q[k-1];
    end
  end

  always_comb begin
    squash_n = '0;
    occ      = '0;
    for (int k = 0; k < STAGES; k++) begin
      squash_n = squash_n + 4'(v_q[k] & flush[k]);
      occ      = occ + OW'(v_q[k]);
    end
  end

  assign fc_sum = {1'b0, fc_q} + {13'd0, squash_n};

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d_q[k] <= '0;
        c_q[k] <= NOP_CTRL;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush[k]) begin
          v_q[k] <= 1'b0;
          d_q[k] <= '0;
          c_q[k] <= NOP_CTRL;
        end else if (rdy[k]) begin
          // An empty source loads a bubble: control goes to NOP, data is left alone.
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            d_q[k] <= src_d[k];
            c_q[k] <= src_c[k];
          end else begin
            c_q[k] <= NOP_CTRL;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      fc_q <= '0;
    end else begin
      fc_q <= fc_sum[16] ? 16'hFFFF : fc_sum[15:0];
    end
  end

  assign in_ready    = rdy[0];
  assign out_valid   = avail[STAGES-1];
  assign out_data    = d_q[STAGES-1];
  assign out_ctrl    = c_q[STAGES-1];
  assign stage_valid = v_q;
  assign occupancy   = occ;
  assign flush_count = fc_q;

endmodule
